simon_autoplayer: RTL and testbench
===================================

SIMON_AUTOPLAYER -- requirements
Module: simon_autoplayer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with ports pclk and rst.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pclk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  autoplay active; low forces idle behaviour.
- mode_leds  input  3  game mode driven by the Simon game.
- pattern_leds  input  4  pattern shown by the game.
- pattern  output  4  pattern presented to the game's pattern input.
- seq_len  output  7  number of entries captured in the last playback, 0..64.
- overflow  output  1  sticky; capture exceeded 64 entries.
- game_over  output  1  high while mode_leds equals DONE.

Function
REQ-003 Mode codes SHALL be INPUT=3'b001, PLAYBACK=3'b010, REPEAT=3'b100, DONE=3'b111; any other code SHALL be treated as IDLE.
REQ-004 The FSM states SHALL be IDLE, GEN, CAPTURE, REPLAY, DONE. The next state SHALL be taken directly from the decoded mode_leds each cycle. enable=0 SHALL force IDLE.
REQ-005 In GEN, pattern SHALL be combinationally one-hot, 4'b0001 << lfsr[1:0], so it is legal at either level. The LFSR SHALL advance once per cycle while in GEN.
REQ-006 In CAPTURE, each cycle SHALL write pattern_leds into mem[wptr] and increment wptr. wptr SHALL be 0 on the first CAPTURE cycle; it is cleared whenever the state is not CAPTURE.
REQ-007 On a write with wptr=63, the entry SHALL be written, wptr SHALL saturate at 63, and seq_len SHALL become 64. Any further CAPTURE cycle SHALL set overflow and leave mem unchanged.
REQ-008 On the CAPTURE-to-any transition, seq_len SHALL latch the number of entries written. seq_len SHALL hold until the next CAPTURE completes.
REQ-009 In REPLAY, pattern SHALL be combinationally mem[rptr], so there is zero latency and mem[0] appears in the first REPLAY cycle.
REQ-010 rptr SHALL increment every REPLAY cycle and is cleared whenever the state is not REPLAY.
REQ-011 When rptr is at or above seq_len during REPLAY, pattern SHALL be 4'b0000 and rptr SHALL hold.
REQ-012 In IDLE and DONE, pattern SHALL be 4'b0000. game_over SHALL equal (state==DONE).
REQ-013 A simultaneous mode change and enable fall SHALL resolve to IDLE. An enable fall mid-CAPTURE SHALL latch seq_len per REQ-008.
REQ-014 Memory SHALL be 64x4, synchronous write and asynchronous read. Its contents are not reset.

Reset
REQ-015 While rst=1, the following SHALL hold:
- state=IDLE, wptr=0, rptr=0.
- seq_len=0, overflow=0, game_over=0, pattern=4'b0000.
- lfsr=8'hA5.
REQ-016 Reset asserted mid-CAPTURE or mid-REPLAY SHALL abandon the operation. After reset releases, behaviour SHALL be as from power-up.

Structure
REQ-017 A shared package simon_pkg SHALL hold:
- the mode codes;
- MAX_LEN=64;
- PTR_W=6;
- LEN_W=7.
REQ-018 One sub-module, simon_lfsr, SHALL implement the LFSR:
- 8-bit Fibonacci;
- taps x^8+x^6+x^5+x^4+1;
- ports: clock, reset, advance, state.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: rst=1 then release with mode_leds=INPUT -> first pattern is 4'b0001<<(8'hA5[1:0]) = 4'b0010; seq_len=0, overflow=0.
- Capture and replay: PLAYBACK for 3 cycles with pattern_leds 1,4,8, then REPEAT -> seq_len=3; pattern=1,4,8 on REPEAT cycles 0..2, then 0.
- Overflow: PLAYBACK for 66 cycles -> seq_len=64, overflow=1; REPLAY cycle 63 returns the 64th captured value.
- Enable drop: enable=0 during REPEAT -> pattern=0 the same cycle; re-enable in REPEAT -> replay restarts at mem[0].
- Done: mode_leds=DONE -> game_over=1, pattern=0; illegal mode 3'b011 -> IDLE, pattern=0.
- Reset mid-CAPTURE after 2 writes -> seq_len=0, state IDLE; a subsequent REPEAT outputs 0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon autoplayer: game mode codes, sizes,
// the player state encoding and the mode decoder.
package simon_pkg;

  localparam int MAX_LEN = 64;
  localparam int PTR_W   = 6;
  localparam int LEN_W   = 7;

  localparam logic [2:0] MODE_INPUT    = 3'b001;
  localparam logic [2:0] MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] MODE_REPEAT   = 3'b100;
  localparam logic [2:0] MODE_DONE     = 3'b111;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CAPTURE,
    S_REPLAY,
    S_DONE
  } state_t;

  // Unknown mode codes fall back to IDLE so a glitching game never drives us.
  function automatic state_t decode_mode(input logic [2:0] mode);
    case (mode)
      MODE_INPUT:    decode_mode = S_GEN;
      MODE_PLAYBACK: decode_mode = S_CAPTURE;
      MODE_REPEAT:   decode_mode = S_REPLAY;
      MODE_DONE:     decode_mode = S_DONE;
      default:       decode_mode = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with
// the feedback bit entering at bit 0.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] state
);

  logic feedback;

  assign feedback = state[7] ^ state[5] ^ state[4] ^ state[3];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= {state[6:0], feedback};
    end
  end

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: follows the game's mode LEDs, feeds random presses while
// the game asks for input, records the shown pattern and replays it on repeat.
module simon_autoplayer
  import simon_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode_leds,
  input  logic [3:0]       pattern_leds,
  output logic [3:0]       pattern,
  output logic [LEN_W-1:0] seq_len,
  output logic             overflow,
  output logic             game_over
);

  state_t state, next_state;

  logic [PTR_W-1:0] wptr;
  logic             full;
  logic [LEN_W-1:0] rptr;
  logic [3:0]       mem [MAX_LEN];
  logic [7:0]       lfsr;
  logic             lfsr_unused;

  logic             capturing;
  logic             write_en;
  logic             last_write;
  logic [LEN_W-1:0] entries;

  simon_lfsr u_lfsr (
    .clk     (pclk),
    .rst     (rst),
    .advance (state == S_GEN),
    .state   (lfsr)
  );

  // Only the two low LFSR bits select a button; the rest only feed the shift.
  assign lfsr_unused = ^lfsr[7:2];

  always_comb begin
    next_state = enable ? decode_mode(mode_leds) : S_IDLE;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign capturing  = (state == S_CAPTURE);
  assign write_en   = capturing && !full;
  assign last_write = write_en && (wptr == PTR_W'(MAX_LEN - 1));
  // Entries held once this cycle's write (if any) has landed.
  assign entries    = full ? LEN_W'(MAX_LEN) : {1'b0, wptr} + LEN_W'(1);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      full     <= 1'b0;
      seq_len  <= '0;
      overflow <= 1'b0;
    end else if (capturing) begin
      if (full) begin
        overflow <= 1'b1;
      end else if (last_write) begin
        full <= 1'b1;
      end else begin
        wptr <= wptr + PTR_W'(1);
      end
      if (last_write || next_state != S_CAPTURE) begin
        seq_len <= entries;
      end
    end else begin
      wptr <= '0;
      full <= 1'b0;
    end
  end

  // NOTE: the pattern store has no reset; replay never reads past seq_len,
  // which is reset, so stale contents are never visible.
  always_ff @(posedge pclk) begin
    if (write_en) begin
      mem[wptr] <= pattern_leds;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
    end else if (state != S_REPLAY) begin
      rptr <= '0;
    end else if (rptr < seq_len) begin
      rptr <= rptr + LEN_W'(1);
    end
  end

  // NOTE: pattern gets its default before the case so no path can infer a latch.
  always_comb begin
    pattern = 4'b0000;
    if (enable) begin
      case (state)
        S_GEN:    pattern = 4'b0001 << lfsr[1:0];
        S_REPLAY: if (rptr < seq_len) pattern = mem[rptr[PTR_W-1:0]];
        default:  pattern = 4'b0000;
      endcase
    end
  end

  assign game_over = (state == S_DONE);

endmodule

// File: tb/tb_simon_autoplayer.sv
// Self-checking bench for simon_autoplayer: directed game scenarios followed
// by a randomized mode walk, all checked against a phase-level game model.
module tb_simon_autoplayer;
  import simon_pkg::*;

  logic       pclk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] mode_leds;
  logic [3:0] pattern_leds;
  logic [3:0] pattern;
  logic [6:0] seq_len;
  logic       overflow;
  logic       game_over;

  int compared   = 0;
  int mismatched = 0;

  simon_autoplayer dut (
    .pclk         (pclk),
    .rst          (rst),
    .enable       (enable),
    .mode_leds    (mode_leds),
    .pattern_leds (pattern_leds),
    .pattern      (pattern),
    .seq_len      (seq_len),
    .overflow     (overflow),
    .game_over    (game_over)
  );

  always #5 pclk = ~pclk;

  // Reference model: which phase of the game we are in, a list of recorded
  // presses, how far replay has got, and the random source.
  typedef enum {PH_IDLE, PH_GEN, PH_CAP, PH_REP, PH_DONE} phase_t;

  phase_t     m_phase;
  logic [7:0] m_lfsr;
  logic [3:0] m_mem [64];
  int         m_written;
  int         m_len;
  int         m_rd;
  bit         m_ovf;

  function automatic phase_t phase_of(input logic [2:0] m);
    case (m)
      3'b001:  return PH_GEN;
      3'b010:  return PH_CAP;
      3'b100:  return PH_REP;
      3'b111:  return PH_DONE;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] exp_pattern();
    logic [3:0] r;
    r = 4'b0000;
    if (enable) begin
      if (m_phase == PH_GEN) r = 4'b0001 << m_lfsr[1:0];
      else if (m_phase == PH_REP && m_rd < m_len) r = m_mem[m_rd];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_lfsr    = 8'hA5;
    m_written = 0;
    m_len     = 0;
    m_rd      = 0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_clock();
    phase_t nxt;
    nxt = enable ? phase_of(mode_leds) : PH_IDLE;
    case (m_phase)
      PH_GEN: m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      PH_CAP: begin
        if (m_written < 64) begin
          m_mem[m_written] = pattern_leds;
          m_written++;
          if (m_written == 64) m_len = 64;
        end else begin
          m_ovf = 1'b1;
        end
      end
      PH_REP: if (m_rd < m_len) m_rd++;
      default: ;
    endcase
    if (m_phase == PH_CAP && nxt != PH_CAP) m_len = m_written;
    if (nxt != PH_CAP) m_written = 0;
    if (nxt != PH_REP) m_rd = 0;
    m_phase = nxt;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pattern"},   {4'b0, pattern},   {4'b0, exp_pattern()});
    check({tag, ".seq_len"},   {1'b0, seq_len},   8'(m_len));
    check({tag, ".overflow"},  {7'b0, overflow},  {7'b0, m_ovf});
    check({tag, ".game_over"}, {7'b0, game_over}, {7'b0, m_phase == PH_DONE});
  endtask

  // Drive one cycle of inputs (from a negedge), check the combinational
  // response, clock, then check the registered response at the next negedge.
  task automatic step(input logic en, input logic [2:0] mode, input logic [3:0] leds,
                      input string tag);
    enable       = en;
    mode_leds    = mode;
    pattern_leds = leds;
    #1;
    check({tag, ".comb"}, {4'b0, pattern}, {4'b0, exp_pattern()});
    @(posedge pclk);
    model_clock();
    @(negedge pclk);
    check_outputs(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] v64;
    logic [2:0] cur_mode;
    logic [2:0] modes [8];
    logic       en_r;

    modes = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b010, 3'b100, 3'b000, 3'b011};

    // Reset with the game already asking for input.
    rst = 1'b1; enable = 1'b1; mode_leds = MODE_INPUT; pattern_leds = 4'h0;
    model_reset();
    repeat (2) @(negedge pclk);
    check_outputs("reset");
    rst = 1'b0;
    step(1'b1, MODE_INPUT, 4'h0, "gen0");
    check("gen0.first", {4'b0, pattern}, 8'h02);
    repeat (5) step(1'b1, MODE_INPUT, 4'($urandom), "gen");

    // Capture three presses then replay them.
    step(1'b1, MODE_PLAYBACK, 4'h0, "cap_enter");
    step(1'b1, MODE_PLAYBACK, 4'h1, "cap1");
    step(1'b1, MODE_PLAYBACK, 4'h4, "cap4");
    step(1'b1, MODE_REPEAT,   4'h8, "cap8");
    check("rep.seq_len", {1'b0, seq_len}, 8'd3);
    check("rep0", {4'b0, pattern}, 8'h1);
    step(1'b1, MODE_REPEAT, 4'h0, "rep1");
    check("rep1.val", {4'b0, pattern}, 8'h4);
    step(1'b1, MODE_REPEAT, 4'h0, "rep2");
    check("rep2.val", {4'b0, pattern}, 8'h8);
    step(1'b1, MODE_REPEAT, 4'h0, "rep3");
    check("rep3.val", {4'b0, pattern}, 8'h0);
    step(1'b1, MODE_REPEAT, 4'h0, "rep4");

    // Capture past the 64-entry limit.
    v64 = 4'h0;
    step(1'b1, MODE_PLAYBACK, 4'h0, "ovf_enter");
    for (int i = 0; i < 66; i++) begin
      pattern_leds = 4'($urandom);
      if (i == 63) v64 = pattern_leds;
      step(1'b1, MODE_PLAYBACK, pattern_leds, "ovf_cap");
    end
    step(1'b1, MODE_REPEAT, 4'h0, "ovf_exit");
    check("ovf.seq_len", {1'b0, seq_len}, 8'd64);
    check("ovf.flag", {7'b0, overflow}, 8'd1);
    repeat (63) step(1'b1, MODE_REPEAT, 4'h0, "ovf_rep");
    check("ovf.rep63", {4'b0, pattern}, {4'b0, v64});
    step(1'b1, MODE_REPEAT, 4'h0, "ovf_rep64");
    check("ovf.rep64", {4'b0, pattern}, 8'h0);

    // Enable drop mid-replay and restart.
    step(1'b1, MODE_PLAYBACK, 4'h0, "drop_enter");
    step(1'b1, MODE_PLAYBACK, 4'h6, "drop_cap_a");
    step(1'b1, MODE_REPEAT,   4'h9, "drop_cap_b");
    step(1'b1, MODE_REPEAT,   4'h0, "drop_rep");
    enable = 1'b0;
    #1;
    check("drop.same_cycle", {4'b0, pattern}, 8'h0);
    step(1'b0, MODE_REPEAT, 4'h0, "drop_idle");
    step(1'b1, MODE_REPEAT, 4'h0, "reenable");
    check("reenable.mem0", {4'b0, pattern}, 8'h6);

    // Done and illegal mode codes.
    step(1'b1, MODE_DONE, 4'h0, "done");
    check("done.game_over", {7'b0, game_over}, 8'd1);
    check("done.pattern", {4'b0, pattern}, 8'h0);
    step(1'b1, 3'b011, 4'h0, "illegal");
    check("illegal.game_over", {7'b0, game_over}, 8'd0);

    // Reset in the middle of a capture after two writes.
    step(1'b1, MODE_PLAYBACK, 4'h0, "rmid_enter");
    step(1'b1, MODE_PLAYBACK, 4'h3, "rmid_a");
    step(1'b1, MODE_PLAYBACK, 4'h5, "rmid_b");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rmid_reset");
    @(negedge pclk);
    rst = 1'b0;
    step(1'b1, MODE_REPEAT, 4'h0, "rmid_rep");
    check("rmid.seq_len", {1'b0, seq_len}, 8'd0);
    check("rmid.pattern", {4'b0, pattern}, 8'h0);
    step(1'b1, MODE_REPEAT, 4'h0, "rmid_rep1");

    // Random walk through game modes with occasional enable drops.
    cur_mode = MODE_INPUT;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_mode = modes[$urandom_range(0, 7)];
      en_r = ($urandom_range(0, 9) != 0);
      step(en_r, cur_mode, 4'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
